if_fetch_unit: RTL and testbench

Instruction-fetch stage feeding the ID stage of the 5-stage MIPS pipeline. It owns the PC register and the fetch handshake to instruction memory, and it loads the IF/ID pipeline register. The redirect pulse from the ID-stage branch comparator (branch/jump/exception decision) arrives here with its resolved target, and this block steers the PC and flushes the wrong-path fetch.

---
 rtl/if_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, runs the imem fetch handshake and loads the IF/ID register.
// Optional `define FETCH_DELAY_SLOT_EN keeps the branch delay-slot instruction on redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_instr_out,
    output logic        if_valid_out
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] target_aligned;
    logic [31:0] seq_pc;
    logic        take_redirect;

`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
`endif

    assign target_aligned = {redirect_target_in[31:2], 2'b00};
    assign take_redirect  = redirect_in && !stall_in;

    // Once the delay slot has been acked, the pending target replaces the sequential PC.
`ifdef FETCH_DELAY_SLOT_EN
    assign seq_pc = pend_q ? pend_pc_q : pc_q + PC_STEP;
`else
    assign seq_pc = pc_q + PC_STEP;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            if_valid_q   <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_valid_d   = if_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
`ifdef FETCH_DELAY_SLOT_EN
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (take_redirect) begin
                    pc_d = target_aligned;
                end
            end
            FETCH: begin
`ifdef FETCH_DELAY_SLOT_EN
                if (take_redirect && !pend_q) begin
                    if (imem_ack_in) begin
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata_in;
                        if_valid_d = 1'b1;
                        pc_d       = target_aligned;
                    end else begin
                        pend_d     = 1'b1;
                        pend_pc_d  = target_aligned;
                        if_valid_d = 1'b0;
                    end
                end else
`else
                if (take_redirect) begin
                    pc_d       = target_aligned;
                    if_valid_d = 1'b0;
                end else
`endif
                if (imem_ack_in) begin
                    pc_d = seq_pc;
`ifdef FETCH_DELAY_SLOT_EN
                    pend_d = 1'b0;
`endif
                    if (stall_in) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata_in;
                        state_d      = HOLD;
                    end else begin
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata_in;
                        if_valid_d = 1'b1;
                    end
                end else if (!stall_in) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!stall_in) begin
                    state_d = FETCH;
`ifdef FETCH_DELAY_SLOT_EN
                    // The held word is the delay slot; release it and steer the PC together.
                    if_pc_d    = hold_pc_q;
                    if_instr_d = hold_instr_q;
                    if_valid_d = 1'b1;
                    if (redirect_in && !pend_q) begin
                        pc_d = target_aligned;
                    end
`else
                    if (redirect_in) begin
                        pc_d       = target_aligned;
                        if_valid_d = 1'b0;
                    end else begin
                        if_pc_d    = hold_pc_q;
                        if_instr_d = hold_instr_q;
                        if_valid_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_out  = (state_q == FETCH);
    assign imem_addr_out = pc_q;
    assign if_pc_out     = if_pc_q;
    assign if_instr_out  = if_instr_q;
    assign if_valid_out  = if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit (base build): one table row per rising edge,
// plus a hand-written asynchronous-reset-mid-fetch sequence.
module tb_if_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] if_pc_out;
    logic [31:0] if_instr_out;
    logic        if_valid_out;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    if_fetch_unit #(.RESET_PC(32'h0040_0000), .PC_STEP(32'd4)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .stall_in           (stall_in),
        .redirect_in        (redirect_in),
        .redirect_target_in (redirect_target_in),
        .imem_req_out       (imem_req_out),
        .imem_addr_out      (imem_addr_out),
        .imem_ack_in        (imem_ack_in),
        .imem_rdata_in      (imem_rdata_in),
        .if_pc_out          (if_pc_out),
        .if_instr_out       (if_instr_out),
        .if_valid_out       (if_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rd;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic stall, logic rd, logic [31:0] tgt, logic ack,
                                logic [31:0] rdata, logic req, logic [31:0] addr,
                                logic [31:0] pc, logic [31:0] instr, logic valid);
        vec_t v;
        v.rst = 1'b1; v.stall = stall; v.rd = rd; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.pc = pc; v.instr = instr; v.valid = valid;
        return v;
    endfunction

    task automatic check(string name, logic req, logic [31:0] addr, logic [31:0] pc,
                         logic [31:0] instr, logic valid);
        n_vec++;
        if (imem_req_out !== req) begin
            n_bad++;
            $display("FAIL %s req: got %b want %b", name, imem_req_out, req);
        end
        if (imem_addr_out !== addr) begin
            n_bad++;
            $display("FAIL %s addr: got %h want %h", name, imem_addr_out, addr);
        end
        if (if_pc_out !== pc) begin
            n_bad++;
            $display("FAIL %s if_pc: got %h want %h", name, if_pc_out, pc);
        end
        if (if_instr_out !== instr) begin
            n_bad++;
            $display("FAIL %s if_instr: got %h want %h", name, if_instr_out, instr);
        end
        if (if_valid_out !== valid) begin
            n_bad++;
            $display("FAIL %s if_valid: got %b want %b", name, if_valid_out, valid);
        end
    endtask

    task automatic drive(logic rst, logic stall, logic rd, logic [31:0] tgt, logic ack,
                         logic [31:0] rdata);
        rst_in = rst; stall_in = stall; redirect_in = rd;
        redirect_target_in = tgt; imem_ack_in = ack; imem_rdata_in = rdata;
    endtask

    initial begin
        //                 stall rd  tgt           ack  rdata     req  addr          if_pc         instr     v
        vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0040_0000, 32'h0,         32'h0,    0);
        vecs[1]  = mk(0, 0, 32'h0,         1, 32'hA0,   1, 32'h0040_0004, 32'h0040_0000, 32'hA0,   1);
        vecs[2]  = mk(0, 0, 32'h0,         1, 32'hA4,   1, 32'h0040_0008, 32'h0040_0004, 32'hA4,   1);
        vecs[3]  = mk(0, 0, 32'h0,         1, 32'hA8,   1, 32'h0040_000C, 32'h0040_0008, 32'hA8,   1);
        vecs[4]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0040_000C, 32'h0040_0008, 32'hA8,   0);
        vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0040_000C, 32'h0040_0008, 32'hA8,   0);
        vecs[6]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0040_000C, 32'h0040_0008, 32'hA8,   0);
        vecs[7]  = mk(0, 0, 32'h0,         1, 32'hC0,   1, 32'h0040_0010, 32'h0040_000C, 32'hC0,   1);
        // stall coincident with ack: into HOLD, req drops, IF/ID frozen for 4 cycles
        vecs[8]  = mk(1, 0, 32'h0,         1, 32'hD0,   0, 32'h0040_0014, 32'h0040_000C, 32'hC0,   1);
        vecs[9]  = mk(1, 0, 32'h0,         0, 32'h0,    0, 32'h0040_0014, 32'h0040_000C, 32'hC0,   1);
        vecs[10] = mk(1, 0, 32'h0,         0, 32'h0,    0, 32'h0040_0014, 32'h0040_000C, 32'hC0,   1);
        vecs[11] = mk(1, 0, 32'h0,         0, 32'h0,    0, 32'h0040_0014, 32'h0040_000C, 32'hC0,   1);
        vecs[12] = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0040_0014, 32'h0040_0010, 32'hD0,   1);
        vecs[13] = mk(0, 0, 32'h0,         1, 32'hE0,   1, 32'h0040_0018, 32'h0040_0014, 32'hE0,   1);
        // redirect with same-cycle ack: ack discarded, bubble, refetch at target
        vecs[14] = mk(0, 1, 32'h0040_0100, 1, 32'hF0,   1, 32'h0040_0100, 32'h0040_0014, 32'hE0,   0);
        // redirect while stalled is ignored
        vecs[15] = mk(1, 1, 32'h0040_0300, 0, 32'h0,    1, 32'h0040_0100, 32'h0040_0014, 32'hE0,   0);
        vecs[16] = mk(0, 0, 32'h0,         1, 32'hB0,   1, 32'h0040_0104, 32'h0040_0100, 32'hB0,   1);
        // misaligned target is forced to a word boundary
        vecs[17] = mk(0, 1, 32'h0040_0203, 0, 32'h0,    1, 32'h0040_0200, 32'h0040_0100, 32'hB0,   0);
        // redirect beats HOLD release; held word discarded
        vecs[18] = mk(1, 0, 32'h0,         1, 32'hC4,   0, 32'h0040_0204, 32'h0040_0100, 32'hB0,   0);
        vecs[19] = mk(0, 1, 32'h0040_0400, 0, 32'h0,    1, 32'h0040_0400, 32'h0040_0100, 32'hB0,   0);
        // PC wrap at the top of the address space
        vecs[20] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,    1, 32'hFFFF_FFFC, 32'h0040_0100, 32'hB0,   0);
        vecs[21] = mk(0, 0, 32'h0,         1, 32'h99,   1, 32'h0000_0000, 32'hFFFF_FFFC, 32'h99,   1);
        vecs[22] = mk(0, 0, 32'h0,         1, 32'h77,   1, 32'h0000_0004, 32'h0000_0000, 32'h77,   1);
        vecs[23] = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h0000_0004, 32'h0000_0000, 32'h77,   0);

        drive(0, 0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk_in);
        #1 check("reset", 0, 32'h0040_0000, 32'h0, 32'h0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_in);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rd, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
            @(posedge clk_in);
            #1 check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pc,
                     vecs[i].instr, vecs[i].valid);
        end

        // asynchronous reset mid-wait (req=1, no ack): outputs clear without a clock edge
        #2 rst_in = 1'b0;
        #1 check("async_rst", 0, 32'h0040_0000, 32'h0, 32'h0, 0);
        @(negedge clk_in);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk_in);
        #1 check("rst_release", 1, 32'h0040_0000, 32'h0, 32'h0, 0);
        @(negedge clk_in);
        drive(1, 0, 0, 32'h0, 1, 32'h5A);
        @(posedge clk_in);
        #1 check("refetch", 1, 32'h0040_0004, 32'h0040_0000, 32'h5A, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
